interrupt_controller: RTL

//  Collects two asynchronous external interrupt lines, synchronises, latches and prioritises them,
//  and presents one request (IRQ_Int, IID_Sync) to the branch/exception controller.

---
 rtl/interrupt_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Synchronises, latches and prioritises two external interrupt
//               lines and sequences the request/acknowledge/service handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int NUM_SYNC  = 2,
    parameter bit EDGE_TRIG = 1'b1,
    parameter bit PRIO_ID   = 1'b1
) (
    input  logic       Clock,
    input  logic       SysReset,
    input  logic [1:0] IRQ_In,
    input  logic       IntEnWE,
    input  logic [1:0] IntEnData,
    input  logic       Supervisor,
    input  logic       IntAck,
    output logic       IRQ_Int,
    output logic       IID_Sync,
    output logic [1:0] IntEn,
    output logic [1:0] Pending,
    output logic       InService
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ENTER = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic C_PRIO = PRIO_ID;

    logic [1:0][NUM_SYNC-1:0] sync_q, sync_d;
    logic [1:0]               prev_q, prev_d;
    logic [1:0]               pending_q, pending_d;
    logic [1:0]               int_en_q, int_en_d;
    logic                     id_q, id_d;
    logic                     irq_q, irq_d;
    logic                     iid_q, iid_d;
    logic                     in_service_q, in_service_d;
    state_t                   state_q, state_d;

    logic [1:0] w_sync;
    logic [1:0] w_rise;
    logic [1:0] w_eligible;
    logic [1:0] w_ack_clr;
    logic       w_sel;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][NUM_SYNC-2:0], IRQ_In[i]};
            w_sync[i] = sync_q[i][NUM_SYNC-1];
        end
        prev_d     = w_sync;
        w_rise     = w_sync & ~prev_q;
        int_en_d   = IntEnWE ? IntEnData : int_en_q;
        w_eligible = pending_q & int_en_q;
        w_sel      = w_eligible[PRIO_ID] ? C_PRIO : ~C_PRIO;
    end

    // Handshake FSM; request id is frozen on entry to REQ.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        w_ack_clr = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (w_eligible != 2'b00) begin
                    state_d = ST_REQ;
                    id_d    = w_sel;
                end
            end
            ST_REQ: begin
                if (IntAck) begin
                    state_d         = ST_ENTER;
                    w_ack_clr[id_q] = 1'b1;
                end else if (!w_eligible[id_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENTER: begin
                if (Supervisor) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!Supervisor) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge wins over an acknowledge clear so no event is lost.
        if (EDGE_TRIG) pending_d = (pending_q & ~w_ack_clr) | w_rise;
        else           pending_d = w_sync;

        irq_d        = (state_d == ST_REQ);
        iid_d        = (state_d == ST_REQ) ? id_d : 1'b0;
        in_service_d = (state_d == ST_ENTER) || (state_d == ST_RUN);
    end

    always_ff @(posedge Clock) begin
        if (SysReset) begin
            sync_q       <= '0;
            prev_q       <= 2'b00;
            pending_q    <= 2'b00;
            int_en_q     <= 2'b00;
            id_q         <= 1'b0;
            irq_q        <= 1'b0;
            iid_q        <= 1'b0;
            in_service_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            int_en_q     <= int_en_d;
            id_q         <= id_d;
            irq_q        <= irq_d;
            iid_q        <= iid_d;
            in_service_q <= in_service_d;
            state_q      <= state_d;
        end
    end

    assign IRQ_Int   = irq_q;
    assign IID_Sync  = iid_q;
    assign IntEn     = int_en_q;
    assign Pending   = pending_q;
    assign InService = in_service_q;

endmodule
`default_nettype wire
